// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share one float adder. Each transaction moves
// A and B (two 16-bit words each, high first) from the granted requester, feeds
// them to the adder, collects Z and returns it to the same requester.
module adder_arbiter (
   input  logic        clk,
   input  logic        rst,
   // requester 0
   input  logic [15:0] r0_a,
   input  logic        r0_a_stb,
   output logic        r0_a_ack,
   input  logic [15:0] r0_b,
   input  logic        r0_b_stb,
   output logic        r0_b_ack,
   output logic [15:0] r0_z,
   output logic        r0_z_stb,
   input  logic        r0_z_ack,
   // requester 1
   input  logic [15:0] r1_a,
   input  logic        r1_a_stb,
   output logic        r1_a_ack,
   input  logic [15:0] r1_b,
   input  logic        r1_b_stb,
   output logic        r1_b_ack,
   output logic [15:0] r1_z,
   output logic        r1_z_stb,
   input  logic        r1_z_ack,
   // shared adder
   output logic [15:0] add_a,
   output logic        add_a_stb,
   input  logic        add_a_ack,
   output logic [15:0] add_b,
   output logic        add_b_stb,
   input  logic        add_b_ack,
   input  logic [15:0] add_z,
   input  logic        add_z_stb,
   output logic        add_z_ack,
   // status
   output logic        grant,
   output logic        busy
);

   typedef enum logic [3:0] {
      StIdle,
      StGetAHi,
      StGetALo,
      StGetBHi,
      StGetBLo,
      StPutAHi,
      StPutALo,
      StPutBHi,
      StPutBLo,
      StGetZHi,
      StGetZLo,
      StPutZHi,
      StPutZLo
   } state_e;

   state_e      state_q, state_d;
   logic        grant_q, grant_d;
   // requester favoured on the next tie
   logic        rr_q, rr_d;

   // per-requester handshakes, bit index = requester number
   logic [1:0]  a_ack_q, a_ack_d;
   logic [1:0]  b_ack_q, b_ack_d;
   logic [1:0]  z_stb_q, z_stb_d;

   logic        add_a_stb_q, add_a_stb_d;
   logic        add_b_stb_q, add_b_stb_d;
   logic        add_z_ack_q, add_z_ack_d;

   // operand and result buffers
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] z_q, z_d;

   // outgoing words, only updated when the matching stb is raised
   logic [15:0] add_a_q, add_a_d;
   logic [15:0] add_b_q, add_b_d;
   logic [15:0] z_word_q, z_word_d;

   // inputs of the granted requester
   logic [15:0] sel_a;
   logic [15:0] sel_b;
   logic        sel_a_stb;
   logic        sel_b_stb;
   logic        sel_z_ack;

   assign sel_a     = grant_q ? r1_a     : r0_a;
   assign sel_b     = grant_q ? r1_b     : r0_b;
   assign sel_a_stb = grant_q ? r1_a_stb : r0_a_stb;
   assign sel_b_stb = grant_q ? r1_b_stb : r0_b_stb;
   assign sel_z_ack = grant_q ? r1_z_ack : r0_z_ack;

   // Next-state and handshake sequencing: each word takes one cycle to raise
   // ack/stb and completes on the edge where both sides are high.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_d        = rr_q;
      a_ack_d     = a_ack_q;
      b_ack_d     = b_ack_q;
      z_stb_d     = z_stb_q;
      add_a_stb_d = add_a_stb_q;
      add_b_stb_d = add_b_stb_q;
      add_z_ack_d = add_z_ack_q;
      a_d         = a_q;
      b_d         = b_q;
      z_d         = z_q;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      z_word_d    = z_word_q;

      unique case (state_q)
         StIdle: begin
            if (r0_a_stb || r1_a_stb) begin
               if (r0_a_stb && r1_a_stb) begin
                  grant_d = rr_q;
               end else begin
                  grant_d = r1_a_stb;
               end
               rr_d    = ~grant_d;
               state_d = StGetAHi;
            end
         end

         StGetAHi: begin
            if (!a_ack_q[grant_q]) begin
               a_ack_d[grant_q] = 1'b1;
            end else if (sel_a_stb) begin
               a_d[31:16]       = sel_a;
               a_ack_d[grant_q] = 1'b0;
               state_d          = StGetALo;
            end
         end

         StGetALo: begin
            if (!a_ack_q[grant_q]) begin
               a_ack_d[grant_q] = 1'b1;
            end else if (sel_a_stb) begin
               a_d[15:0]        = sel_a;
               a_ack_d[grant_q] = 1'b0;
               state_d          = StGetBHi;
            end
         end

         StGetBHi: begin
            if (!b_ack_q[grant_q]) begin
               b_ack_d[grant_q] = 1'b1;
            end else if (sel_b_stb) begin
               b_d[31:16]       = sel_b;
               b_ack_d[grant_q] = 1'b0;
               state_d          = StGetBLo;
            end
         end

         StGetBLo: begin
            if (!b_ack_q[grant_q]) begin
               b_ack_d[grant_q] = 1'b1;
            end else if (sel_b_stb) begin
               b_d[15:0]        = sel_b;
               b_ack_d[grant_q] = 1'b0;
               state_d          = StPutAHi;
            end
         end

         StPutAHi: begin
            if (!add_a_stb_q) begin
               add_a_d     = a_q[31:16];
               add_a_stb_d = 1'b1;
            end else if (add_a_ack) begin
               add_a_stb_d = 1'b0;
               state_d     = StPutALo;
            end
         end

         StPutALo: begin
            if (!add_a_stb_q) begin
               add_a_d     = a_q[15:0];
               add_a_stb_d = 1'b1;
            end else if (add_a_ack) begin
               add_a_stb_d = 1'b0;
               state_d     = StPutBHi;
            end
         end

         StPutBHi: begin
            if (!add_b_stb_q) begin
               add_b_d     = b_q[31:16];
               add_b_stb_d = 1'b1;
            end else if (add_b_ack) begin
               add_b_stb_d = 1'b0;
               state_d     = StPutBLo;
            end
         end

         StPutBLo: begin
            if (!add_b_stb_q) begin
               add_b_d     = b_q[15:0];
               add_b_stb_d = 1'b1;
            end else if (add_b_ack) begin
               add_b_stb_d = 1'b0;
               state_d     = StGetZHi;
            end
         end

         StGetZHi: begin
            if (!add_z_ack_q) begin
               add_z_ack_d = 1'b1;
            end else if (add_z_stb) begin
               z_d[31:16]  = add_z;
               add_z_ack_d = 1'b0;
               state_d     = StGetZLo;
            end
         end

         StGetZLo: begin
            if (!add_z_ack_q) begin
               add_z_ack_d = 1'b1;
            end else if (add_z_stb) begin
               z_d[15:0]   = add_z;
               add_z_ack_d = 1'b0;
               state_d     = StPutZHi;
            end
         end

         StPutZHi: begin
            if (!z_stb_q[grant_q]) begin
               z_word_d         = z_q[31:16];
               z_stb_d[grant_q] = 1'b1;
            end else if (sel_z_ack) begin
               z_stb_d[grant_q] = 1'b0;
               state_d          = StPutZLo;
            end
         end

         StPutZLo: begin
            if (!z_stb_q[grant_q]) begin
               z_word_d         = z_q[15:0];
               z_stb_d[grant_q] = 1'b1;
            end else if (sel_z_ack) begin
               z_stb_d[grant_q] = 1'b0;
               state_d          = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Control state: reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         grant_q     <= 1'b0;
         rr_q        <= 1'b0;
         a_ack_q     <= 2'b00;
         b_ack_q     <= 2'b00;
         z_stb_q     <= 2'b00;
         add_a_stb_q <= 1'b0;
         add_b_stb_q <= 1'b0;
         add_z_ack_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_q        <= rr_d;
         a_ack_q     <= a_ack_d;
         b_ack_q     <= b_ack_d;
         z_stb_q     <= z_stb_d;
         add_a_stb_q <= add_a_stb_d;
         add_b_stb_q <= add_b_stb_d;
         add_z_ack_q <= add_z_ack_d;
      end
   end

   // Data buffers carry no reset; they are only read once written.
   always_ff @(posedge clk) begin
      a_q      <= a_d;
      b_q      <= b_d;
      z_q      <= z_d;
      add_a_q  <= add_a_d;
      add_b_q  <= add_b_d;
      z_word_q <= z_word_d;
   end

   assign r0_a_ack  = a_ack_q[0];
   assign r1_a_ack  = a_ack_q[1];
   assign r0_b_ack  = b_ack_q[0];
   assign r1_b_ack  = b_ack_q[1];
   assign r0_z_stb  = z_stb_q[0];
   assign r1_z_stb  = z_stb_q[1];
   // both requesters see the same result word; only the stb selects
   assign r0_z      = z_word_q;
   assign r1_z      = z_word_q;
   assign add_a     = add_a_q;
   assign add_a_stb = add_a_stb_q;
   assign add_b     = add_b_q;
   assign add_b_stb = add_b_stb_q;
   assign add_z_ack = add_z_ack_q;
   assign grant     = grant_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: requester and adder agents plus a transaction-level
// model of arbitration and word ordering checked every cycle.
module tb_adder_arbiter;

   localparam logic [31:0] F1 = 32'h3F800000;
   localparam logic [31:0] F2 = 32'h40000000;

   logic             clk;
   logic             rst;
   logic [1:0][15:0] req_a;
   logic [1:0][15:0] req_b;
   logic [1:0][15:0] z_w;
   logic [1:0]       a_stb, b_stb, z_ack;
   logic [1:0]       a_ack, b_ack, z_stb;
   logic [15:0]      add_a, add_b, add_z;
   logic             add_a_stb, add_a_ack, add_b_stb, add_b_ack;
   logic             add_z_stb, add_z_ack;
   logic             grant, busy;

   int n_vec;
   int n_err;

   adder_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .r0_a      (req_a[0]),
      .r0_a_stb  (a_stb[0]),
      .r0_a_ack  (a_ack[0]),
      .r0_b      (req_b[0]),
      .r0_b_stb  (b_stb[0]),
      .r0_b_ack  (b_ack[0]),
      .r0_z      (z_w[0]),
      .r0_z_stb  (z_stb[0]),
      .r0_z_ack  (z_ack[0]),
      .r1_a      (req_a[1]),
      .r1_a_stb  (a_stb[1]),
      .r1_a_ack  (a_ack[1]),
      .r1_b      (req_b[1]),
      .r1_b_stb  (b_stb[1]),
      .r1_b_ack  (b_ack[1]),
      .r1_z      (z_w[1]),
      .r1_z_stb  (z_stb[1]),
      .r1_z_ack  (z_ack[1]),
      .add_a     (add_a),
      .add_a_stb (add_a_stb),
      .add_a_ack (add_a_ack),
      .add_b     (add_b),
      .add_b_stb (add_b_stb),
      .add_b_ack (add_b_ack),
      .add_z     (add_z),
      .add_z_stb (add_z_stb),
      .add_z_ack (add_z_ack),
      .grant     (grant),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Float add for positive normal operands, truncating.
   function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] t;
      logic [24:0] mx, my, m;
      logic [7:0]  e;
      int          d;
      if (x[30:23] < y[30:23]) begin
         t = x;
         x = y;
         y = t;
      end
      d  = int'(x[30:23]) - int'(y[30:23]);
      mx = {2'b01, x[22:0]};
      my = {2'b01, y[22:0]} >> d;
      m  = mx + my;
      e  = x[30:23];
      if (m[24]) begin
         m = m >> 1;
         e = e + 8'd1;
      end
      return {1'b0, e, m[22:0]};
   endfunction

   // ---------------- agents ----------------
   logic [31:0] tx_a [2][16];
   logic [31:0] tx_b [2][16];
   int          tx_head [2];
   int          tx_tail [2];
   int          a_cnt [2];
   int          b_cnt [2];
   int          z_cnt [2];
   logic [15:0] z_hi [2];
   logic [1:0]  bp_hold;
   logic [31:0] res_z [32];
   int          res_who [32];
   int          res_n;
   logic [31:0] ad_a, ad_b, ad_z;
   int          ad_a_cnt, ad_b_cnt, ad_z_cnt, ad_wait, ad_delay;
   logic        ad_ready;

   task automatic push(input int n, input logic [31:0] a, input logic [31:0] b);
      tx_a[n][tx_tail[n]] = a;
      tx_b[n][tx_tail[n]] = b;
      tx_tail[n]++;
   endtask

   task automatic env_clear();
      for (int n = 0; n < 2; n++) begin
         tx_head[n] = tx_tail[n];
         a_cnt[n]   = 0;
         b_cnt[n]   = 0;
         z_cnt[n]   = 0;
      end
      ad_a_cnt = 0;
      ad_b_cnt = 0;
      ad_z_cnt = 0;
      ad_wait  = 0;
      ad_ready = 1'b0;
   endtask

   initial begin
      for (int n = 0; n < 2; n++) begin
         tx_head[n] = 0;
         tx_tail[n] = 0;
      end
      res_n     = 0;
      ad_delay  = 0;
      bp_hold   = 2'b00;
      env_clear();
      a_stb     = 2'b00;
      b_stb     = 2'b00;
      z_ack     = 2'b11;
      req_a     = '0;
      req_b     = '0;
      add_a_ack = 1'b1;
      add_b_ack = 1'b1;
      add_z_stb = 1'b0;
      add_z     = 16'h0;
      forever begin
         // transfers seen here complete on the coming rising edge
         @(negedge clk);
         if (!rst) begin
            env_clear();
         end else begin
            for (int n = 0; n < 2; n++) begin
               if (a_stb[n] && a_ack[n]) a_cnt[n]++;
               if (b_stb[n] && b_ack[n]) b_cnt[n]++;
               if (z_stb[n] && z_ack[n]) begin
                  if (z_cnt[n] == 0) begin
                     z_hi[n]  = z_w[n];
                     z_cnt[n] = 1;
                  end else begin
                     res_z[res_n]   = {z_hi[n], z_w[n]};
                     res_who[res_n] = n;
                     res_n++;
                     tx_head[n]++;
                     a_cnt[n] = 0;
                     b_cnt[n] = 0;
                     z_cnt[n] = 0;
                  end
               end
            end
            if (add_a_stb && add_a_ack) begin
               if (ad_a_cnt == 0) ad_a[31:16] = add_a;
               else ad_a[15:0] = add_a;
               ad_a_cnt++;
            end
            if (add_b_stb && add_b_ack) begin
               if (ad_b_cnt == 0) ad_b[31:16] = add_b;
               else ad_b[15:0] = add_b;
               ad_b_cnt++;
            end
            if (add_z_stb && add_z_ack) begin
               ad_z_cnt++;
               if (ad_z_cnt == 2) begin
                  ad_ready = 1'b0;
                  ad_a_cnt = 0;
                  ad_b_cnt = 0;
                  ad_z_cnt = 0;
               end
            end else if (ad_ready && ad_wait > 0) begin
               ad_wait--;
            end
            if (!ad_ready && ad_a_cnt == 2 && ad_b_cnt == 2) begin
               ad_z     = fadd(ad_a, ad_b);
               ad_ready = 1'b1;
               ad_wait  = ad_delay;
            end
         end
         @(posedge clk);
         #1;
         for (int n = 0; n < 2; n++) begin
            a_stb[n] = (tx_head[n] < tx_tail[n]) && (a_cnt[n] < 2);
            b_stb[n] = (tx_head[n] < tx_tail[n]) && (b_cnt[n] < 2);
            req_a[n] = (a_cnt[n] == 0) ? tx_a[n][tx_head[n]][31:16] : tx_a[n][tx_head[n]][15:0];
            req_b[n] = (b_cnt[n] == 0) ? tx_b[n][tx_head[n]][31:16] : tx_b[n][tx_head[n]][15:0];
            z_ack[n] = !bp_hold[n];
         end
         add_z_stb = ad_ready && (ad_wait == 0);
         add_z     = (ad_z_cnt == 0) ? ad_z[31:16] : ad_z[15:0];
      end
   end

   // ---------------- model and compare ----------------
   logic        m_busy, m_grant, rr_m, zs_pend, o;
   logic [15:0] zs_word;
   logic [31:0] e_a, e_b, e_z;
   int          m_aw, m_bw, m_zw, m_cycles, last_lat, n_grants;
   logic        grant_log [64];

   initial begin
      m_busy   = 1'b0;
      m_grant  = 1'b0;
      rr_m     = 1'b0;
      zs_pend  = 1'b0;
      last_lat = 0;
      n_grants = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("reset_outputs", 32'({busy, grant, a_ack, b_ack, z_stb, add_a_stb, add_b_stb,
                                        add_z_ack}), 32'd0);
            m_busy  = 1'b0;
            rr_m    = 1'b0;
            zs_pend = 1'b0;
         end else if (m_busy) begin
            m_cycles++;
            check("busy_high", 32'(busy), 32'd1);
            check("grant_held", 32'(grant), 32'(m_grant));
            o = ~m_grant;
            check("other_quiet", 32'({a_ack[o], b_ack[o], z_stb[o]}), 32'd0);
            if (z_stb != 2'b00) check("z_mirror", 32'(z_w[0]), 32'(z_w[1]));
            if (zs_pend) begin
               check("z_stb_held", 32'(z_stb[m_grant]), 32'd1);
               check("z_word_held", 32'(z_w[m_grant]), 32'(zs_word));
            end
            zs_pend = z_stb[m_grant] && !z_ack[m_grant];
            zs_word = z_w[m_grant];
            if (add_a_stb && add_a_ack) begin
               check("add_a_word", 32'(add_a), (m_aw == 0) ? 32'(e_a[31:16]) : 32'(e_a[15:0]));
               m_aw++;
            end
            if (add_b_stb && add_b_ack) begin
               check("add_b_word", 32'(add_b), (m_bw == 0) ? 32'(e_b[31:16]) : 32'(e_b[15:0]));
               m_bw++;
            end
            if (z_stb[m_grant] && z_ack[m_grant]) begin
               check("z_word", 32'(z_w[m_grant]), (m_zw == 0) ? 32'(e_z[31:16]) : 32'(e_z[15:0]));
               m_zw++;
               if (m_zw == 2) begin
                  check("word_counts", 32'(m_aw * 16 + m_bw), 32'(2 * 16 + 2));
                  m_busy   = 1'b0;
                  last_lat = m_cycles;
               end
            end
         end else begin
            check("idle_outputs", 32'({busy, a_ack, b_ack, z_stb, add_a_stb, add_b_stb,
                                       add_z_ack}), 32'd0);
            if (a_stb != 2'b00) begin
               m_grant  = (a_stb == 2'b11) ? rr_m : a_stb[1];
               rr_m     = ~m_grant;
               m_busy   = 1'b1;
               m_cycles = 0;
               m_aw     = 0;
               m_bw     = 0;
               m_zw     = 0;
               zs_pend  = 1'b0;
               e_a      = tx_a[m_grant][tx_head[m_grant]];
               e_b      = tx_b[m_grant][tx_head[m_grant]];
               e_z      = fadd(e_a, e_b);
               grant_log[n_grants] = m_grant;
               n_grants++;
            end
         end
      end
   end

   // ---------------- directed sequence ----------------
   task automatic wait_idle(input int budget);
      logic done;
      done = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (busy === 1'b0 && tx_head[0] == tx_tail[0] && tx_head[1] == tx_tail[1] && !ad_ready) begin
            done = 1'b1;
            break;
         end
      end
      check("wait_idle", 32'(done), 32'd1);
   endtask

   // 0: r1_z_stb high, 1: add_z_ack high, 2: PUT_B_LO word presented
   task automatic wait_for(input int what, input int budget);
      logic done;
      done = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if ((what == 0 && z_stb[1] === 1'b1) || (what == 1 && add_z_ack === 1'b1) ||
             (what == 2 && add_b_stb === 1'b1 && add_b === 16'h0000 && busy === 1'b1)) begin
            done = 1'b1;
            break;
         end
      end
      check("wait_event", 32'(done), 32'd1);
   endtask

   logic exp_seq [4];
   int   g0, r0i;

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_state", 32'({busy, grant, a_ack, b_ack, z_stb, add_a_stb, add_b_stb,
                              add_z_ack}), 32'd0);
      #1 rst = 1'b1;

      // tie after reset: r0 first
      @(posedge clk);
      #2;
      r0i = res_n;
      push(0, F1, F1);
      push(1, F2, F2);
      wait_idle(200);
      check("tie_first_who", 32'(res_who[r0i]), 32'd0);
      check("tie_first_z", res_z[r0i], 32'h40000000);
      check("tie_second_who", 32'(res_who[r0i + 1]), 32'd1);
      check("tie_second_z", res_z[r0i + 1], 32'h40800000);

      // both requesting continuously for four transactions
      g0 = n_grants;
      push(0, F1, F2);
      push(0, F2, F2);
      push(1, F1, F1);
      push(1, F2, F1);
      wait_idle(400);
      exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) check("rr_grant_seq", 32'(grant_log[g0 + i]), 32'(exp_seq[i]));

      // single request, zero-wait environment
      r0i = res_n;
      push(0, F1, F2);
      wait_idle(200);
      check("single_who", 32'(res_who[r0i]), 32'd0);
      check("single_z", res_z[r0i], 32'h40400000);
      check("single_latency", 32'(last_lat), 32'd24);

      // back-pressure on r1 result; r0 requests meanwhile
      r0i = res_n;
      bp_hold[1] = 1'b1;
      push(1, F1, F2);
      wait_for(0, 200);
      push(0, F2, F1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_z_stb", 32'(z_stb[1]), 32'd1);
         check("bp_z_word", 32'(z_w[1]), 32'h4040);
         check("bp_busy", 32'(busy), 32'd1);
         check("bp_grant", 32'(grant), 32'd1);
      end
      bp_hold[1] = 1'b0;
      wait_idle(300);
      check("bp_first_who", 32'(res_who[r0i]), 32'd1);
      check("bp_first_z", res_z[r0i], 32'h40400000);
      check("bp_second_who", 32'(res_who[r0i + 1]), 32'd0);

      // adder stall
      r0i = res_n;
      ad_delay = 50;
      push(0, F2, F2);
      wait_for(1, 200);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check("stall_z_ack", 32'(add_z_ack), 32'd1);
         check("stall_no_z_stb", 32'(z_stb), 32'd0);
      end
      ad_delay = 0;
      wait_idle(300);
      check("stall_z", res_z[r0i], 32'h40800000);
      check("stall_latency_long", 32'(last_lat > 50), 32'd1);

      // reset during PUT_B_LO, between clock edges
      r0i = res_n;
      push(0, F1, F1);
      wait_for(2, 200);
      #1 rst = 1'b0;
      #1;
      check("async_reset", 32'({busy, grant, a_ack, b_ack, z_stb, add_a_stb, add_b_stb,
                                add_z_ack}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      check("no_partial_result", 32'(res_n), 32'(r0i));
      push(1, F1, F2);
      wait_idle(200);
      check("fresh_count", 32'(res_n), 32'(r0i + 1));
      check("fresh_who", 32'(res_who[r0i]), 32'd1);
      check("fresh_z", res_z[r0i], 32'h40400000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have no parameters; word width is fixed at 16 bits; operands/results are 32-bit floats carried as two words, high word first.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 r0_a, r1_a  input  16  requester operand A words.
REQ-005 r0_a_stb, r1_a_stb  input  1  A word valid; r0_a_ack, r1_a_ack  output  1  A word accepted.
REQ-006 r0_b, r1_b  input  16  operand B words; r0_b_stb, r1_b_stb input 1; r0_b_ack, r1_b_ack output 1.
REQ-007 r0_z, r1_z  output  16  result words; r0_z_stb, r1_z_stb output 1; r0_z_ack, r1_z_ack input 1.
REQ-008 add_a, add_b  output  16  operand words to shared adder; add_a_stb, add_b_stb output 1; add_a_ack, add_b_ack input 1.
REQ-009 add_z  input  16  adder result word; add_z_stb input 1; add_z_ack output 1.
REQ-010 grant  output  1  index of requester owning the current transaction (valid while busy=1).
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 Every transfer on every port SHALL complete on a rising edge where stb and ack are both high; each transfer moves exactly one word.
REQ-013 Acks driven by the block SHALL be registered: set on the first cycle of a receiving state, cleared on the edge a transfer completes.
REQ-014 Stbs driven by the block SHALL be registered, with data stable while stb is high, cleared on the edge the transfer completes.
REQ-015 States: IDLE, GET_A_HI, GET_A_LO, GET_B_HI, GET_B_LO, PUT_A_HI, PUT_A_LO, PUT_B_HI, PUT_B_LO, GET_Z_HI, GET_Z_LO, PUT_Z_HI, PUT_Z_LO, strictly in this order, PUT_Z_LO returning to IDLE.
REQ-016 IDLE: if exactly one rN_a_stb is high, grant=N and go to GET_A_HI; if neither, stay.
REQ-017 IDLE tie (both rN_a_stb high): grant the requester not granted in the previous transaction (round-robin pointer); after reset the pointer favours r0.
REQ-018 Round-robin pointer SHALL update only on entry to GET_A_HI.
REQ-019 GET_* states: assert only the granted requester's a_ack/b_ack and buffer the words into internal 32-bit A and B registers.
REQ-020 PUT_A_*/PUT_B_*: present buffered high then low words on add_a/add_b with add_a_stb/add_b_stb.
REQ-021 GET_Z_*: assert add_z_ack, capture add_z into a 32-bit Z register, high word first.
REQ-022 PUT_Z_*: drive granted rN_z/rN_z_stb with Z high then low word.
REQ-023 The non-granted requester's acks and z_stb SHALL remain 0 for the entire transaction; its strobes are ignored.
REQ-024 A new request SHALL NOT be accepted until PUT_Z_LO completes; no limit on cycles spent waiting in any state (stalling stb or ack holds state indefinitely).
REQ-025 r0_z and r1_z SHALL both carry the Z register word; only z_stb differs.
REQ-026 Minimum transaction latency: 2 cycles per word transfer (ack/stb set, then complete), 12 words, i.e. 24 cycles from IDLE grant to return to IDLE, excluding adder compute time.
REQ-027 grant SHALL remain constant from entry to GET_A_HI until return to IDLE.

Reset
REQ-028 While rst=0, immediately (asynchronously): state=IDLE, all acks and stbs=0, busy=0, grant=0, round-robin pointer favours r0.
REQ-029 Data registers (A, B, Z, add_a, add_b, rN_z) need not be reset.
REQ-030 Reset mid-transaction SHALL abandon it with no partial result returned; the system resets the shared adder on the same rst.

Verification
REQ-031 Single request: r0 sends A=0x3F800000 (1.0), B=0x40000000 (2.0) -> r0_z returns 0x4040 then 0x0000; grant=0; r1 acks stay 0.
REQ-032 Tie after reset: r0 and r1 raise a_stb same cycle -> r0 served first (A=1.0,B=1.0 -> 0x40000000), then r1 (A=2.0,B=2.0 -> 0x40800000).
REQ-033 Round-robin: r0 and r1 both continuously requesting for 4 transactions -> grant sequence 0,1,0,1.
REQ-034 Back-pressure: r1 holds r1_z_ack=0 for 20 cycles in PUT_Z_HI -> r1_z_stb and r1_z=high word held stable, busy=1, r0 request not granted until completion.
REQ-035 Reset mid-transaction: assert rst=0 during PUT_B_LO -> all stb/ack outputs 0 and busy=0 same cycle without a clock edge; after release a fresh r1 request completes correctly.
REQ-036 Adder stall: add_z_stb delayed 50 cycles -> add_z_ack held 1 in GET_Z_HI, no requester z_stb asserted until result captured.
